// File: rtl/pattern_vector_sequencer.sv
// Built-in test sequencer: drives LFSR pattern vectors into a combinational graph,
// compacts its outputs into a MISR signature and compares against a golden value.
module pattern_vector_sequencer #(
  parameter int unsigned IN_W        = 15,
  parameter int unsigned OUT_W       = 13,
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter logic [15:0] SEED        = 16'h0001
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      golden_sig,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [15:0]      vec_count
);

  localparam int unsigned CNT_W        = 4;
  localparam logic [15:0] SEED_EFF     = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [15:0] LAST_VEC     = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [15:0]      misr_next;
  logic [CNT_W-1:0] settle_cnt;

  // Both registers use the same x^16+x^14+x^13+x^11+1 feedback taps.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign misr_next = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
                     ^ 16'(dut_out);

  // dut_in/busy/done are kept as flops updated alongside each state transition,
  // so the graph inputs never see a combinational path from start/abort.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state      <= IDLE;
      lfsr       <= SEED_EFF;
      signature  <= 16'h0000;
      vec_count  <= 16'h0000;
      settle_cnt <= '0;
      pass       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dut_in     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            lfsr       <= SEED_EFF;
            signature  <= 16'h0000;
            vec_count  <= 16'h0000;
            settle_cnt <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            dut_in     <= SEED_EFF[IN_W-1:0];
          end
        end
        APPLY: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            pass   <= 1'b0;
            dut_in <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= CAPTURE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            pass   <= 1'b0;
            dut_in <= '0;
          end else begin
            signature <= misr_next;
            lfsr      <= lfsr_next;
            vec_count <= vec_count + 16'd1;
            if (vec_count == LAST_VEC) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              dut_in <= '0;
              pass   <= (misr_next == golden_sig);
            end else begin
              state  <= APPLY;
              dut_in <= lfsr_next[IN_W-1:0];
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          dut_in <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_vector_sequencer.sv
// Scoreboard bench for pattern_vector_sequencer: three instances with different
// run lengths / settle times, expected captures queued by a reference model.
module tb_pattern_vector_sequencer;

  localparam int unsigned NV_T [3] = '{4, 2, 8};
  localparam int unsigned ST_T [3] = '{1, 1, 2};
  localparam logic [15:0] SEED_T [3] = '{16'h0001, 16'h0001, 16'h0000};

  typedef struct packed {
    logic [1:0]  id;
    logic [14:0] din;
    logic [15:0] sig;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  start;
  logic [2:0]  abort;
  logic [15:0] golden [3];
  logic [12:0] dut_out [3];
  logic [14:0] dut_in [3];
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  pass;
  logic [15:0] sig [3];
  logic [15:0] vcnt [3];
  int          mode;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [12:0] o);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {3'b000, o};
  endfunction

  // Stand-in for the graph under test; mode picks zero, constant-one or a mixing function.
  function automatic logic [12:0] gfun(input logic [14:0] x, input int md);
    case (md)
      0:       return 13'h0000;
      1:       return 13'h0001;
      default: return x[12:0] ^ {x[14:13], x[14:4]};
    endcase
  endfunction

  assign dut_out[0] = gfun(dut_in[0], mode);
  assign dut_out[1] = gfun(dut_in[1], mode);
  assign dut_out[2] = gfun(dut_in[2], mode);

  pattern_vector_sequencer #(.IN_W(15), .OUT_W(13), .NUM_VECTORS(NV_T[0]),
                             .SETTLE_CYC(ST_T[0]), .SEED(SEED_T[0])) u_a (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start[0]), .abort(abort[0]),
    .golden_sig(golden[0]), .dut_out(dut_out[0]), .dut_in(dut_in[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .signature(sig[0]), .vec_count(vcnt[0]));

  pattern_vector_sequencer #(.IN_W(15), .OUT_W(13), .NUM_VECTORS(NV_T[1]),
                             .SETTLE_CYC(ST_T[1]), .SEED(SEED_T[1])) u_b (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start[1]), .abort(abort[1]),
    .golden_sig(golden[1]), .dut_out(dut_out[1]), .dut_in(dut_in[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .signature(sig[1]), .vec_count(vcnt[1]));

  pattern_vector_sequencer #(.IN_W(15), .OUT_W(13), .NUM_VECTORS(NV_T[2]),
                             .SETTLE_CYC(ST_T[2]), .SEED(SEED_T[2])) u_c (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start[2]), .abort(abort[2]),
    .golden_sig(golden[2]), .dut_out(dut_out[2]), .dut_in(dut_in[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .signature(sig[2]), .vec_count(vcnt[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every vec_count increment pops one expected capture.
  logic [15:0] prev_cnt [3];
  logic [14:0] last_din [3];
  exp_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst && vcnt[i] == prev_cnt[i] + 16'd1) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("sb_id", 32'(i), 32'(mon_e.id));
            check("sb_din", 32'(last_din[i]), 32'(mon_e.din));
            check("sb_sig", 32'(sig[i]), 32'(mon_e.sig));
            check("sb_cnt", 32'(vcnt[i]), 32'(mon_e.cnt));
          end
        end
        prev_cnt[i] = vcnt[i];
        if (busy[i]) last_din[i] = dut_in[i];
      end
    end
  end

  task automatic build_model(input int i, input int ncap, output logic [15:0] fsig);
    logic [15:0] l;
    logic [15:0] m;
    exp_t        e;
    l = (SEED_T[i] == 16'h0000) ? 16'h0001 : SEED_T[i];
    m = 16'h0000;
    for (int v = 0; v < ncap; v++) begin
      e.id  = 2'(i);
      e.din = l[14:0];
      m     = misr_step(m, gfun(l[14:0], mode));
      e.sig = m;
      e.cnt = 16'(v + 1);
      sb_q.push_back(e);
      l = lfsr_step(l);
    end
    fsig = m;
  endtask

  // Returns at the falling edge right after the edge that samples start.
  task automatic pulse_start(input int i, input logic with_abort);
    @(negedge clk);
    start[i] = 1'b1;
    abort[i] = with_abort;
    @(posedge clk);
    @(negedge clk);
    start[i] = 1'b0;
    abort[i] = 1'b0;
  endtask

  // edges0 = rising edges already elapsed, counting the start-sampling edge as 1.
  task automatic wait_done(input int i, input int edges0);
    int edges;
    int exp_edges;
    edges = edges0;
    exp_edges = 1 + int'(NV_T[i]) * (int'(ST_T[i]) + 1);
    while (!done[i] && edges < 4000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("done_latency", 32'(edges), 32'(exp_edges));
  endtask

  logic [15:0] fs;
  logic [15:0] fs_first;

  initial begin
    rst = 1'b1;
    start = '0;
    abort = '0;
    mode = 0;
    for (int i = 0; i < 3; i++) golden[i] = 16'h0000;

    // Reset held while inputs toggle
    repeat (4) begin
      @(negedge clk);
      start = 3'($urandom);
      abort = 3'($urandom);
      mode  = int'($urandom_range(0, 2));
      for (int i = 0; i < 3; i++) golden[i] = 16'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_pass", 32'(pass[i]), 32'd0);
      check("rst_dut_in", 32'(dut_in[i]), 32'd0);
      check("rst_sig", 32'(sig[i]), 32'd0);
      check("rst_vcnt", 32'(vcnt[i]), 32'd0);
    end
    start = '0;
    abort = '0;
    mode = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy[0]), 32'd0);
    check("idle_dut_in", 32'(dut_in[0]), 32'd0);
    check("idle_done", 32'(done[0]), 32'd0);

    // Four vectors, zero graph outputs
    golden[0] = 16'h0000;
    build_model(0, 4, fs_first);
    pulse_start(0, 1'b0);
    check("a_busy", 32'(busy[0]), 32'd1);
    check("a_first_in", 32'(dut_in[0]), 32'h0001);
    wait_done(0, 1);
    check("a_sig", 32'(sig[0]), 32'h0000);
    check("a_pass", 32'(pass[0]), 32'd1);
    check("a_vcnt", 32'(vcnt[0]), 32'd4);
    check("a_done_in", 32'(dut_in[0]), 32'd0);
    check("a_drain", 32'(sb_q.size()), 32'd0);

    // Restart from DONE replays the same run
    build_model(0, 4, fs);
    pulse_start(0, 1'b0);
    check("re_pass", 32'(pass[0]), 32'd0);
    check("re_vcnt", 32'(vcnt[0]), 32'd0);
    check("re_sig", 32'(sig[0]), 32'd0);
    check("re_done", 32'(done[0]), 32'd0);
    wait_done(0, 1);
    check("re_final", 32'(sig[0]), 32'(fs_first));
    check("re_pass_end", 32'(pass[0]), 32'd1);

    // Constant-one output, matching then mismatching golden
    mode = 1;
    golden[1] = 16'h0003;
    build_model(1, 2, fs);
    pulse_start(1, 1'b0);
    wait_done(1, 1);
    check("b_sig", 32'(sig[1]), 32'h0003);
    check("b_pass", 32'(pass[1]), 32'd1);
    golden[1] = 16'h0004;
    build_model(1, 2, fs);
    pulse_start(1, 1'b0);
    wait_done(1, 1);
    check("b_sig2", 32'(sig[1]), 32'h0003);
    check("b_fail_pass", 32'(pass[1]), 32'd0);

    // Abort in the capture cycle of vector 3 (seed 0 maps to 1)
    mode = 2;
    golden[2] = 16'h0000;
    build_model(2, 2, fs);
    pulse_start(2, 1'b0);
    repeat (8) @(negedge clk);
    abort[2] = 1'b1;
    @(negedge clk);
    abort[2] = 1'b0;
    check("ab_busy", 32'(busy[2]), 32'd0);
    check("ab_done", 32'(done[2]), 32'd0);
    check("ab_dut_in", 32'(dut_in[2]), 32'd0);
    check("ab_vcnt", 32'(vcnt[2]), 32'd2);
    check("ab_sig", 32'(sig[2]), 32'(fs));
    check("ab_pass", 32'(pass[2]), 32'd0);
    @(negedge clk);
    check("ab_hold_sig", 32'(sig[2]), 32'(fs));
    check("ab_drain", 32'(sb_q.size()), 32'd0);

    // Full run with matching golden; abort ignored in DONE
    build_model(2, 8, fs);
    golden[2] = fs;
    pulse_start(2, 1'b0);
    wait_done(2, 1);
    check("c_pass", 32'(pass[2]), 32'd1);
    check("c_vcnt", 32'(vcnt[2]), 32'd8);
    check("c_sig", 32'(sig[2]), 32'(fs));
    abort[2] = 1'b1;
    @(negedge clk);
    abort[2] = 1'b0;
    check("c_abort_done", 32'(done[2]), 32'd1);
    check("c_abort_pass", 32'(pass[2]), 32'd1);

    // start+abort together in DONE restarts; start while busy is ignored
    build_model(2, 8, fs);
    golden[2] = fs ^ 16'h8000;
    pulse_start(2, 1'b1);
    check("sa_busy", 32'(busy[2]), 32'd1);
    check("sa_pass", 32'(pass[2]), 32'd0);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    @(negedge clk);
    wait_done(2, 3);
    check("sa_sig", 32'(sig[2]), 32'(fs));
    check("sa_fail_pass", 32'(pass[2]), 32'd0);

    // Asynchronous reset during APPLY of vector 5
    build_model(2, 4, fs);
    pulse_start(2, 1'b0);
    repeat (12) @(negedge clk);
    check("mr_pre_vcnt", 32'(vcnt[2]), 32'd4);
    #1 rst = 1'b1;
    #1;
    check("mr_busy", 32'(busy[2]), 32'd0);
    check("mr_dut_in", 32'(dut_in[2]), 32'd0);
    check("mr_sig", 32'(sig[2]), 32'd0);
    check("mr_vcnt", 32'(vcnt[2]), 32'd0);
    check("mr_drain", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    build_model(2, 8, fs);
    golden[2] = fs;
    pulse_start(2, 1'b0);
    wait_done(2, 1);
    check("mr_run_pass", 32'(pass[2]), 32'd1);
    check("mr_run_sig", 32'(sig[2]), 32'(fs));
    check("final_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pattern_vector_sequencer.md
Name: pattern_vector_sequencer

Overview:
Built-in test sequencer for one merged combinational pattern graph: 15 primary inputs, 13 primary outputs.
- Generates pseudo-random input vectors from a 16-bit LFSR.
- Applies each vector, waits a programmable settle time, then compacts the graph outputs into a 16-bit MISR signature.
- At the end of a run, compares the signature against a golden value.
- Sits between the test-control register block and the pattern graph under test.

Parameters:
IN_W, 15, graph input width (1..16); dut_in = lfsr[IN_W-1:0]
OUT_W, 13, graph output width (1..16); zero-extended into MISR
NUM_VECTORS, 256, vectors per run (1..65535)
SETTLE_CYC, 2, cycles each vector is held before capture (1..15)
SEED, 16'h0001, LFSR start value; 0 is replaced by 16'h0001

Ports:
blif_clk_net  in  1  clock, rising edge
blif_reset_net  in  1  asynchronous reset, active-high
start  in  1  begin run; sampled in IDLE or DONE
abort  in  1  terminate run; sampled in APPLY or CAPTURE
golden_sig  in  16  expected signature; sampled on entry to DONE
dut_out  in  OUT_W  graph outputs
dut_in  out  IN_W  graph inputs
busy  out  1  high in APPLY or CAPTURE
done  out  1  high in DONE
pass  out  1  valid while done; signature == golden_sig
signature  out  16  current MISR value
vec_count  out  16  vectors captured in the current or last run

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; lfsr=SEED (or 1 if SEED=0); misr=0; vec_count=0; settle counter=0; pass=0. Resulting outputs: busy=0, done=0, dut_in=0, signature=0.
- dut_in = lfsr[IN_W-1:0] in APPLY and CAPTURE; 0 in all other states. It is decoded from registers only, with no combinational path from any input.
- LFSR step: fb = l[15]^l[13]^l[12]^l[10]; l_next = {l[14:0], fb}.
- MISR step: fb = m[15]^m[13]^m[12]^m[10]; m_next = {m[14:0], fb} ^ zero_extend(dut_out).
- State IDLE:
  - start=1 -> APPLY.
  - On the same edge: lfsr=seed, misr=0, vec_count=0, settle counter=0.
- State APPLY:
  - Settle counter increments each cycle.
  - When counter == SETTLE_CYC-1 -> CAPTURE, counter=0.
- State CAPTURE (exactly 1 cycle):
  - misr=m_next sampling dut_out; lfsr=l_next; vec_count+1.
  - If vec_count (pre-increment) == NUM_VECTORS-1 -> DONE; else -> APPLY.
- State DONE:
  - pass=(misr==golden_sig), registered on the entry edge.
  - Holds until start=1, which restarts exactly as from IDLE and clears pass.
- abort=1 in APPLY or CAPTURE:
  - Next state IDLE. The CAPTURE update is suppressed if abort arrives in CAPTURE.
  - signature and vec_count are frozen at their last values; pass=0.
  - abort has priority over every other transition. abort is ignored in IDLE and DONE.
- Simultaneous start+abort in IDLE or DONE: start wins.
- start while busy: ignored.
- Timing:
  - Each vector occupies SETTLE_CYC+1 cycles.
  - done rises exactly 1+NUM_VECTORS*(SETTLE_CYC+1) edges after the edge that samples start.
- vec_count does not wrap: NUM_VECTORS is at most 65535.
- Reset asserted mid-run returns all state to reset values at once. No partial capture occurs.

Test Plan:
1. Reset with inputs toggling -> busy=0, done=0, pass=0, dut_in=0, signature=16'h0000, vec_count=0. All hold until start.
2. NUM_VECTORS=4, SETTLE_CYC=1, SEED=1, dut_out=0, golden_sig=0:
   - dut_in sequence is 15'h0001, 0002, 0004, 0008, each held 2 cycles.
   - done rises 9 cycles after start; signature=0, pass=1, vec_count=4.
3. NUM_VECTORS=2, SETTLE_CYC=1, dut_out=13'h0001 constant, golden_sig=16'h0003 -> signature 0001 after the first capture, 0003 after the second; pass=1. Repeat with golden_sig=16'h0004 -> pass=0.
4. Abort: NUM_VECTORS=8, abort pulsed in the CAPTURE cycle of vector 3 -> next cycle IDLE, vec_count=2, signature unchanged by that capture, done=0, dut_in=0.
5. Restart from DONE: after scenario 2, pulse start -> pass clears, vec_count=0, signature=0. The sequence replays with the identical final signature.
6. Reset mid-run: assert blif_reset_net during APPLY of vector 5 -> outputs reach reset values before the next clock edge. start after release behaves as scenario 2.
